vmem_term_ctrl: RTL and testbench
=================================

VMEM_TERM_CTRL -- requirements
Module: vmem_term_ctrl

Interface
REQ-001 SHALL use parameters: COLS=70 (text columns); ROWS=30 (text rows); CELLS=2100 (COLS*ROWS, character-memory depth).
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe qualifying key_ascii.
- key_ascii  in  8  ASCII code from the keyboard path.
- key_ready  out  1  high when a key is accepted this cycle.
- clear_req  in  1  request to blank the whole screen.
- rd_addr  out  12  character-memory read address, linear row*COLS+col.
- rd_data  in  8  character-memory read data, valid the cycle after rd_addr.
- wr_en  out  1  character-memory write strobe.
- wr_addr  out  12  character-memory write address, linear.
- wr_data  out  8  character-memory write data.
- cur_col  out  7  cursor column, 0..69.
- cur_row  out  5  cursor row, 0..29.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
REQ-004 SHALL register all outputs; key_ready = (state==IDLE); a key is accepted when key_valid & key_ready in cycle N.
REQ-005 SHALL, in IDLE, give clear_req priority over key_valid in the same cycle; that key is dropped.
REQ-006 SHALL drop key_valid while key_ready is low; no buffering.
REQ-007 Printable 0x20..0x7E: cycle N+1 wr_en=1, wr_addr=row*70+col, wr_data=key_ascii; cursor advances in the same cycle.
REQ-008 Advance: col<69 gives col+1; col==69 gives col=0, row+1; row==29 with col==69 gives col=0, row stays 29, then the scroll sequence.
REQ-009 0x0D (Enter): no character write; col=0 and row+1; at row 29, scroll, cursor ends at (0,29).
REQ-010 0x08 (Backspace): col>0 gives col-1; col==0 and row>0 gives (69,row-1); then writes 0x20 at the new cursor in cycle N+1; at (0,0) no write and no cursor change.
REQ-011 Any other code SHALL be consumed with no write and no cursor change; return to IDLE at N+2.
REQ-012 Single-cell operations SHALL hold key_ready low at N+1 and restore it at N+2.
REQ-013 CLEAR: writes 0x20 to addresses 0..2099, one per cycle, ascending; afterwards cursor=(0,0), then IDLE.
REQ-014 SCROLL, for i=0..2029:
- SCROLL_RD: rd_addr=i+70.
- SCROLL_WR (next cycle): wr_en=1, wr_addr=i, wr_data=rd_data.
REQ-015 SCROLL_BLANK: writes 0x20 to addresses 2030..2099, one per cycle, then IDLE. Total scroll length: 4130 cycles.
REQ-016 wr_en SHALL be 0 in IDLE and SCROLL_RD; addresses SHALL never exceed 2099.
REQ-017 clear_req SHALL be ignored while busy.

Reset
REQ-018 When rst=1 at a clock edge: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, cur_col=0, cur_row=0, busy=0, key_ready=1.
REQ-019 rst during CLEAR or scroll SHALL abort on that edge with no further writes; memory contents are left as-is.

Structure
REQ-020 Package vmem_term_pkg SHALL hold:
- COLS, ROWS, CELLS.
- ASCII constants: CR=0x0D, BS=0x08, SPACE=0x20, printable bounds 0x20/0x7E.
- The FSM state enum.
REQ-021 Sub-module term_cursor SHALL hold col/row registers with advance, newline and retreat commands, and SHALL output a wrap-at-last-row flag and the linear address.

Verification
REQ-022 Bench SHALL cover:
- Reset, then key 0x41 at (0,0): wr_en one cycle, addr 0, data 0x41; cursor (1,0); key_ready low 1 cycle.
- Cursor (69,29), key 0x42: write addr 2099; 2030 copy pairs (e.g. rd 70 then wr 0 with rd_data); 70 blanks at 2030..2099; cursor (0,29); busy for 4130 cycles.
- Backspace at (0,1): space written at addr 69, cursor (69,0); backspace at (0,0): no write.
- clear_req and key_valid in the same IDLE cycle: 2100 space writes at addr 0..2099, key dropped, cursor (0,0).
- rst asserted mid-CLEAR at address 500: no wr_en after that edge, all outputs at reset values.
- key_valid pulsed while busy: no effect on writes or cursor.

Source files
------------

// File: rtl/vmem_term_pkg.sv
// vmem_term_pkg: shared geometry, ASCII codes and FSM state type for the text terminal controller
package vmem_term_pkg;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] PR_LO = 8'h20;
  localparam logic [7:0] PR_HI = 8'h7E;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_BLANK
  } state_e;
endpackage

// File: rtl/term_cursor.sv
// term_cursor: cursor column/row registers with advance, newline, retreat and home commands
module term_cursor
  import vmem_term_pkg::*;
#(
  parameter int COLS = vmem_term_pkg::COLS,
  parameter int ROWS = vmem_term_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  input  logic        nl_i,
  input  logic        ret_i,
  input  logic        home_i,
  output logic [6:0]  col_o,
  output logic [4:0]  row_o,
  output logic        last_row_o,
  output logic        wrap_o,
  output logic [11:0] addr_o
);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       at_home;
  assign at_home = (col_q == '0) && (row_q == '0);
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      col_d = (col_q == COL_MAX) ? '0 : col_q + 7'd1;
      row_d = (col_q == COL_MAX && row_q != ROW_MAX) ? row_q + 5'd1 : row_q;
    end else if (nl_i) begin
      col_d = '0;
      row_d = (row_q != ROW_MAX) ? row_q + 5'd1 : row_q;
    end else if (ret_i && !at_home) begin
      col_d = (col_q == '0) ? COL_MAX : col_q - 7'd1;
      row_d = (col_q == '0) ? row_q - 5'd1 : row_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign col_o      = col_q;
  assign row_o      = row_q;
  assign last_row_o = (row_q == ROW_MAX);
  assign wrap_o     = last_row_o && (col_q == COL_MAX);
  assign addr_o     = 12'(row_q) * 12'(COLS) + 12'(col_q);
endmodule

// File: rtl/vmem_term_ctrl.sv
// vmem_term_ctrl: keyboard-driven text terminal writer for a linear character memory,
// with screen clear and one-line scroll (copy up, blank last row)
module vmem_term_ctrl
  import vmem_term_pkg::*;
#(
  parameter int COLS  = vmem_term_pkg::COLS,
  parameter int ROWS  = vmem_term_pkg::ROWS,
  parameter int CELLS = vmem_term_pkg::CELLS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  input  logic        clear_req,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);
  localparam logic [11:0] LAST      = 12'(CELLS - 1);
  localparam logic [11:0] COPY_LAST = 12'(CELLS - COLS - 1);
  localparam logic [11:0] BLANK0    = 12'(CELLS - COLS);
  localparam logic [11:0] ROW_W     = 12'(COLS);
  state_e      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [11:0] rd_addr_q, rd_addr_d;
  logic        scroll_q, scroll_d;
  logic        key_ready_q, busy_q;
  logic        adv, nl, ret, home;
  logic        last_row, wrap;
  logic [11:0] cur_addr;
  logic        printable;
  term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (adv),
    .nl_i      (nl),
    .ret_i     (ret),
    .home_i    (home),
    .col_o     (cur_col),
    .row_o     (cur_row),
    .last_row_o(last_row),
    .wrap_o    (wrap),
    .addr_o    (cur_addr)
  );
  assign printable = (key_ascii >= PR_LO) && (key_ascii <= PR_HI);
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    scroll_d  = scroll_q;
    adv       = 1'b0;
    nl        = 1'b0;
    ret       = 1'b0;
    home      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = SPACE;
        end else if (key_valid) begin
          state_d  = WRITE;
          scroll_d = 1'b0;
          if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = key_ascii;
            adv       = 1'b1;
            scroll_d  = wrap;
          end else if (key_ascii == CR) begin
            nl       = 1'b1;
            scroll_d = last_row;
          end else if (key_ascii == BS && cur_addr != '0) begin
            // stepping back one linear cell also covers wrapping to the previous row's end
            ret       = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr - 12'd1;
            wr_data_d = SPACE;
          end
        end
      end
      WRITE: begin
        state_d   = scroll_q ? SCROLL_RD : IDLE;
        rd_addr_d = scroll_q ? ROW_W : rd_addr_q;
      end
      CLEAR: begin
        state_d   = (wr_addr_q == LAST) ? IDLE : CLEAR;
        home      = (wr_addr_q == LAST);
        wr_en_d   = (wr_addr_q != LAST);
        wr_addr_d = (wr_addr_q == LAST) ? wr_addr_q : wr_addr_q + 12'd1;
      end
      SCROLL_RD: begin
        state_d   = SCROLL_WR;
        wr_en_d   = 1'b1;
        wr_addr_d = rd_addr_q - ROW_W;
      end
      SCROLL_WR: begin
        if (wr_addr_q == COPY_LAST) begin
          state_d   = SCROLL_BLANK;
          wr_en_d   = 1'b1;
          wr_addr_d = BLANK0;
          wr_data_d = SPACE;
        end else begin
          state_d   = SCROLL_RD;
          rd_addr_d = rd_addr_q + 12'd1;
        end
      end
      SCROLL_BLANK: begin
        state_d   = (wr_addr_q == LAST) ? IDLE : SCROLL_BLANK;
        wr_en_d   = (wr_addr_q != LAST);
        wr_addr_d = (wr_addr_q == LAST) ? wr_addr_q : wr_addr_q + 12'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      scroll_q    <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      scroll_q    <= scroll_d;
      key_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end
  // memory read data only arrives during the copy-write cycle, so it is forwarded straight through
  assign wr_data   = (state_q == SCROLL_WR) ? rd_data : wr_data_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign key_ready = key_ready_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_vmem_term_ctrl.sv
// tb_vmem_term_ctrl: directed checks of key writes, cursor motion, clear, scroll and reset abort
module tb_vmem_term_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        key_ready;
  logic        clear_req = 1'b0;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;
  int total = 0;
  int bad = 0;

  vmem_term_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_ascii(key_ascii),
    .key_ready(key_ready),
    .clear_req(clear_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  // memory model: each cell holds a pattern derived from its address, one-cycle read latency
  always @(posedge clk) rd_data <= rd_addr[7:0] ^ 8'hA5;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_ascii = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic scroll_run(output int cyc, output int errs);
    int a;
    cyc = 0;
    errs = 0;
    while (busy && cyc < 5000) begin
      if (cyc < 4060) begin
        if (cyc % 2 == 0) begin
          if (wr_en !== 1'b0 || rd_addr !== 12'(70 + cyc / 2)) errs++;
        end else begin
          a = (cyc - 1) / 2;
          if (wr_en !== 1'b1 || wr_addr !== 12'(a) || wr_data !== (8'(a + 70) ^ 8'hA5)) errs++;
        end
      end else if (wr_en !== 1'b1 || wr_addr !== 12'(2030 + cyc - 4060) || wr_data !== 8'h20) errs++;
      key_valid = (cyc == 100);
      key_ascii = 8'h21;
      clear_req = (cyc == 200);
      cyc++;
      step();
    end
    key_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    int n, errs, g, c;
    step();
    step();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_ready", key_ready, 1);
    rst = 1'b0;
    step();

    send_key(8'h41);
    chk("A_wr_en", wr_en, 1);
    chk("A_wr_addr", wr_addr, 0);
    chk("A_wr_data", wr_data, 8'h41);
    chk("A_col", cur_col, 1);
    chk("A_row", cur_row, 0);
    chk("A_key_ready_low", key_ready, 0);
    step();
    chk("A_wr_en_off", wr_en, 0);
    chk("A_key_ready_back", key_ready, 1);

    send_key(8'h0D);
    chk("cr_no_write", wr_en, 0);
    chk("cr_col", cur_col, 0);
    chk("cr_row", cur_row, 1);
    step();

    send_key(8'h08);
    chk("bs_wr_en", wr_en, 1);
    chk("bs_wr_addr", wr_addr, 69);
    chk("bs_wr_data", wr_data, 8'h20);
    chk("bs_col", cur_col, 69);
    chk("bs_row", cur_row, 0);
    step();

    key_valid = 1'b1;
    key_ascii = 8'h55;
    clear_req = 1'b1;
    step();
    key_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_busy", busy, 1);
    n = 0;
    errs = 0;
    g = 0;
    while (busy && g < 3000) begin
      if (wr_en) begin
        if (wr_addr !== 12'(n) || wr_data !== 8'h20) errs++;
        n++;
      end
      key_valid = (g == 1000);
      key_ascii = 8'h58;
      clear_req = (g == 1500);
      g++;
      step();
    end
    key_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_count", n, 2100);
    chk("clr_errs", errs, 0);
    chk("clr_col", cur_col, 0);
    chk("clr_row", cur_row, 0);
    chk("clr_idle", key_ready, 1);

    send_key(8'h08);
    chk("bs00_no_write", wr_en, 0);
    chk("bs00_col", cur_col, 0);
    chk("bs00_row", cur_row, 0);
    chk("bs00_key_ready_low", key_ready, 0);
    step();
    chk("bs00_key_ready_back", key_ready, 1);

    send_key(8'h07);
    chk("other_no_write", wr_en, 0);
    chk("other_col", cur_col, 0);
    step();
    chk("other_idle", busy, 0);

    for (int i = 0; i < 29; i++) begin
      send_key(8'h0D);
      step();
    end
    for (int i = 0; i < 69; i++) begin
      send_key(8'h61);
      step();
    end
    chk("pos_col", cur_col, 69);
    chk("pos_row", cur_row, 29);

    send_key(8'h42);
    chk("B_wr_en", wr_en, 1);
    chk("B_wr_addr", wr_addr, 2099);
    chk("B_wr_data", wr_data, 8'h42);
    chk("B_col", cur_col, 0);
    chk("B_row", cur_row, 29);
    chk("B_busy", busy, 1);
    step();
    scroll_run(c, errs);
    chk("scroll1_cycles", c, 4130);
    chk("scroll1_errs", errs, 0);
    chk("scroll1_col", cur_col, 0);
    chk("scroll1_row", cur_row, 29);
    chk("scroll1_key_ready", key_ready, 1);

    send_key(8'h0D);
    chk("cr29_no_write", wr_en, 0);
    chk("cr29_col", cur_col, 0);
    chk("cr29_row", cur_row, 29);
    chk("cr29_busy", busy, 1);
    step();
    scroll_run(c, errs);
    chk("scroll2_cycles", c, 4130);
    chk("scroll2_errs", errs, 0);
    chk("scroll2_col", cur_col, 0);
    chk("scroll2_row", cur_row, 29);

    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    g = 0;
    while (!(wr_en && wr_addr == 12'd500) && g < 1000) begin
      g++;
      step();
    end
    chk("abort_reach_500", wr_addr, 500);
    rst = 1'b1;
    step();
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_col", cur_col, 0);
    chk("abort_row", cur_row, 0);
    chk("abort_busy", busy, 0);
    chk("abort_key_ready", key_ready, 1);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wr_en !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("abort_quiet", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
